// File: rtl/cext_aligner.sv
// -----------------------------------------------------------------------------
// cext_aligner
//
// Instruction realigner for the RISC-V compressed (C) extension. Sits between
// the instruction cache response and the fetch stage. It selects the 16- or
// 32-bit instruction found at a halfword-aligned fetch PC, reports its size so
// fetch can advance by 2 or 4, and assembles 32-bit instructions that straddle
// a word boundary from two consecutive cache words.
//
// Optional feature macro: CEXT_SPLIT_FETCH_EN
//   defined   : straddling instructions are assembled over two cache accesses
//               (RUN -> SPLIT -> RUN); misalign_exc_o is tied low.
//   undefined : no SPLIT state and no holding registers; a straddle is reported
//               combinationally on misalign_exc_o instead.
//
// Parameters
//   XLEN            PC / address width.
//   NOP             instruction driven when no valid instruction is available.
//
// Ports
//   clk             clock.
//   rst_n           asynchronous active-low reset.
//   pc_ff_i         current fetch PC (halfword aligned, bit 0 ignored).
//   icache_valid_i  cache ack; icache_rdata_i is valid this cycle.
//   icache_rdata_i  cache word at icache_addr_o.
//   if_stall_i      fetch is held by the forward/stall unit.
//   flush_i         redirect (new PC from csr/exe, or wfi).
//   icache_addr_o   word-aligned address fetch presents to the cache.
//   instr_o         selected instruction; compressed ones zero-extended.
//   is_comp_o       instr_o is a 16-bit instruction.
//   pc_aligned_o    PC of instr_o.
//   instr_valid_o   instr_o is a real instruction.
//   stall_o         fetch must hold pc_ff.
//   misalign_exc_o  unsupported straddling instruction.
// -----------------------------------------------------------------------------
module cext_aligner #(
    parameter int          XLEN = 32,
    parameter logic [31:0] NOP  = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_ff_i,
    input  logic            icache_valid_i,
    input  logic [31:0]     icache_rdata_i,
    input  logic            if_stall_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] icache_addr_o,
    output logic [31:0]     instr_o,
    output logic            is_comp_o,
    output logic [XLEN-1:0] pc_aligned_o,
    output logic            instr_valid_o,
    output logic            stall_o,
    output logic            misalign_exc_o
);

    // -------------------------------------------------------------------------
    // RUN-mode decode of the current cache word. Purely combinational so an
    // aligned or compressed instruction costs no extra latency.
    // -------------------------------------------------------------------------
    logic [15:0]     run_half;      // halfword addressed by pc_ff_i[1]
    logic [31:0]     run_instr;
    logic            run_comp;
    logic            run_valid;
    logic            run_straddle;  // 32-bit instruction starting in upper half
    logic [XLEN-1:0] run_addr;

    assign run_half = pc_ff_i[1] ? icache_rdata_i[31:16] : icache_rdata_i[15:0];
    assign run_addr = {pc_ff_i[XLEN-1:2], 2'b00};

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        run_instr    = NOP;
        run_comp     = 1'b0;
        run_valid    = 1'b0;
        run_straddle = 1'b0;
        if (icache_valid_i) begin
            if (run_half[1:0] != 2'b11) begin
                // Low two bits other than 2'b11 mark a compressed instruction.
                run_instr = {16'h0000, run_half};
                run_comp  = 1'b1;
                run_valid = 1'b1;
            end else if (!pc_ff_i[1]) begin
                run_instr = icache_rdata_i;
                run_valid = 1'b1;
            end else begin
                // Only the lower half of a 32-bit instruction is in this word.
                run_straddle = 1'b1;
            end
        end
    end

`ifdef CEXT_SPLIT_FETCH_EN

    // -------------------------------------------------------------------------
    // Two-state realigner: SPLIT holds the lower half of a straddling
    // instruction while the following word is fetched.
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     hbuf_q, hbuf_d;   // lower half of the straddling instruction
    logic [XLEN-1:0] spc_q, spc_d;     // PC of the straddling instruction

    // NOTE: state is updated with non-blocking assignments only, and the
    // asynchronous reset clears every register (including mid-SPLIT) so the
    // block never resumes a half-assembled instruction after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            hbuf_q  <= 16'h0000;
            spc_q   <= '0;
        end else begin
            state_q <= state_d;
            hbuf_q  <= hbuf_d;
            spc_q   <= spc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hbuf_d         = hbuf_q;
        spc_d          = spc_q;

        icache_addr_o  = run_addr;
        instr_o        = run_instr;
        is_comp_o      = run_comp;
        pc_aligned_o   = pc_ff_i;
        instr_valid_o  = run_valid;
        stall_o        = 1'b0;
        misalign_exc_o = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                // stall_o depends only on the cache response, never on
                // if_stall_i, so there is no loop through the fetch stall.
                stall_o = run_straddle;
                if (run_straddle && !if_stall_i && !flush_i) begin
                    hbuf_d  = run_half;
                    spc_d   = pc_ff_i;
                    state_d = ST_SPLIT;
                end
            end

            ST_SPLIT: begin
                icache_addr_o = {spc_q[XLEN-1:2], 2'b00} + XLEN'(4);
                pc_aligned_o  = spc_q;
                stall_o       = !icache_valid_i;
                instr_o       = NOP;
                is_comp_o     = 1'b0;
                instr_valid_o = 1'b0;
                if (icache_valid_i) begin
                    // Upper half of the instruction is the low half of word+4.
                    instr_o       = {icache_rdata_i[15:0], hbuf_q};
                    instr_valid_o = 1'b1;
                    // While fetch is held the assembled instruction stays on
                    // the outputs; leave only once fetch accepts it.
                    if (!if_stall_i) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // A redirect discards whatever is in flight, including an instruction
        // assembled in this very cycle.
        if (flush_i) begin
            state_d       = ST_RUN;
            hbuf_d        = 16'h0000;
            instr_valid_o = 1'b0;
            stall_o       = 1'b0;
        end
    end

    // Bit 0 of the PC is never used for selection.
    logic unused_pc_bit0;
    assign unused_pc_bit0 = pc_ff_i[0];

`else

    // -------------------------------------------------------------------------
    // Without split fetch there is no state: a straddle is flagged so that
    // fetch/ID can raise the instruction-misaligned exception.
    // -------------------------------------------------------------------------
    always_comb begin
        icache_addr_o  = run_addr;
        instr_o        = run_instr;
        is_comp_o      = run_comp;
        pc_aligned_o   = pc_ff_i;
        instr_valid_o  = run_valid;
        stall_o        = 1'b0;
        misalign_exc_o = run_straddle;
        if (flush_i) begin
            instr_valid_o = 1'b0;
        end
    end

    // Clock, reset and the fetch stall have no effect in this configuration.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, if_stall_i, pc_ff_i[0]};

`endif

endmodule

// File: tb/tb_cext_aligner.sv
// -----------------------------------------------------------------------------
// tb_cext_aligner
//
// Self-checking bench for cext_aligner. Directed scenarios cover reset, aligned
// and compressed decode, straddle assembly, fetch stall, flush and reset inside
// SPLIT (or the misalign flag when CEXT_SPLIT_FETCH_EN is undefined), followed
// by randomized traffic checked against a behavioural model of the realigner.
// -----------------------------------------------------------------------------
module tb_cext_aligner;

    localparam logic [31:0] NOP_I = 32'h0000_0013;
`ifdef CEXT_SPLIT_FETCH_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_ff_i;
    logic        icache_valid_i;
    logic [31:0] icache_rdata_i;
    logic        if_stall_i;
    logic        flush_i;
    logic [31:0] icache_addr_o;
    logic [31:0] instr_o;
    logic        is_comp_o;
    logic [31:0] pc_aligned_o;
    logic        instr_valid_o;
    logic        stall_o;
    logic        misalign_exc_o;

    int n_cmp  = 0;
    int n_fail = 0;

    cext_aligner #(
        .XLEN (32),
        .NOP  (NOP_I)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_ff_i        (pc_ff_i),
        .icache_valid_i (icache_valid_i),
        .icache_rdata_i (icache_rdata_i),
        .if_stall_i     (if_stall_i),
        .flush_i        (flush_i),
        .icache_addr_o  (icache_addr_o),
        .instr_o        (instr_o),
        .is_comp_o      (is_comp_o),
        .pc_aligned_o   (pc_aligned_o),
        .instr_valid_o  (instr_valid_o),
        .stall_o        (stall_o),
        .misalign_exc_o (misalign_exc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next drive point (just after the following falling edge).
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pc_ff_i        = 32'h8000_0000;
        icache_valid_i = 1'b0;
        icache_rdata_i = 32'h0000_0000;
        if_stall_i     = 1'b0;
        flush_i        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n   = 1'b0;
        pc_ff_i = 32'h1234_5676;
        @(negedge clk);
        #1;
        n_cmp++; if (instr_o !== NOP_I) begin n_fail++; $display("FAIL reset.instr got %h want %h", instr_o, NOP_I); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset.valid got %b want 0", instr_valid_o); end
        n_cmp++; if (is_comp_o !== 1'b0) begin n_fail++; $display("FAIL reset.comp got %b want 0", is_comp_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset.stall got %b want 0", stall_o); end
        n_cmp++; if (misalign_exc_o !== 1'b0) begin n_fail++; $display("FAIL reset.exc got %b want 0", misalign_exc_o); end
        n_cmp++; if (icache_addr_o !== 32'h1234_5674) begin n_fail++; $display("FAIL reset.addr got %h want 12345674", icache_addr_o); end
        n_cmp++; if (pc_aligned_o !== 32'h1234_5676) begin n_fail++; $display("FAIL reset.pc got %h want 12345676", pc_aligned_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned32();
        do_reset();
        pc_ff_i        = 32'h8000_0000;
        icache_valid_i = 1'b1;
        icache_rdata_i = 32'h0050_0093;
        #1;
        n_cmp++; if (instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL aligned32.instr got %h want 00500093", instr_o); end
        n_cmp++; if (is_comp_o !== 1'b0) begin n_fail++; $display("FAIL aligned32.comp got %b want 0", is_comp_o); end
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL aligned32.valid got %b want 1", instr_valid_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL aligned32.stall got %b want 0", stall_o); end
        tick();
    endtask

    task automatic test_comp_pair();
        do_reset();
        pc_ff_i        = 32'h8000_0000;
        icache_valid_i = 1'b1;
        icache_rdata_i = 32'h4501_4085;
        #1;
        n_cmp++; if (instr_o !== 32'h0000_4085) begin n_fail++; $display("FAIL comp_pair.instr0 got %h want 00004085", instr_o); end
        n_cmp++; if (is_comp_o !== 1'b1) begin n_fail++; $display("FAIL comp_pair.comp0 got %b want 1", is_comp_o); end
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL comp_pair.valid0 got %b want 1", instr_valid_o); end
        tick();
        pc_ff_i = 32'h8000_0002;
        #1;
        n_cmp++; if (instr_o !== 32'h0000_4501) begin n_fail++; $display("FAIL comp_pair.instr1 got %h want 00004501", instr_o); end
        n_cmp++; if (is_comp_o !== 1'b1) begin n_fail++; $display("FAIL comp_pair.comp1 got %b want 1", is_comp_o); end
        n_cmp++; if (pc_aligned_o !== 32'h8000_0002) begin n_fail++; $display("FAIL comp_pair.pc1 got %h want 80000002", pc_aligned_o); end
        n_cmp++; if (icache_addr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL comp_pair.addr1 got %h want 80000000", icache_addr_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL comp_pair.stall1 got %b want 0", stall_o); end
        tick();
    endtask

`ifdef CEXT_SPLIT_FETCH_EN
    // Present the straddling first word at 0x8000_0002 and take the edge.
    task automatic enter_split();
        do_reset();
        pc_ff_i        = 32'h8000_0002;
        icache_valid_i = 1'b1;
        icache_rdata_i = 32'h0093_1234;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL split_entry.stall got %b want 1", stall_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL split_entry.valid got %b want 0", instr_valid_o); end
        tick();
    endtask

    task automatic test_straddle();
        enter_split();
        icache_valid_i = 1'b0;
        #1;
        n_cmp++; if (icache_addr_o !== 32'h8000_0004) begin n_fail++; $display("FAIL straddle.addr got %h want 80000004", icache_addr_o); end
        n_cmp++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL straddle.wait_stall got %b want 1", stall_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL straddle.wait_valid got %b want 0", instr_valid_o); end
        n_cmp++; if (misalign_exc_o !== 1'b0) begin n_fail++; $display("FAIL straddle.exc got %b want 0", misalign_exc_o); end
        tick();
        icache_valid_i = 1'b1;
        icache_rdata_i = 32'hABCD_0050;
        #1;
        n_cmp++; if (instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL straddle.instr got %h want 00500093", instr_o); end
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL straddle.valid got %b want 1", instr_valid_o); end
        n_cmp++; if (is_comp_o !== 1'b0) begin n_fail++; $display("FAIL straddle.comp got %b want 0", is_comp_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL straddle.stall got %b want 0", stall_o); end
        n_cmp++; if (pc_aligned_o !== 32'h8000_0002) begin n_fail++; $display("FAIL straddle.pc got %h want 80000002", pc_aligned_o); end
        tick();
        // Back in RUN: fetch has advanced to spc+4 and re-fetches word 1.
        pc_ff_i = 32'h8000_0006;
        #1;
        n_cmp++; if (icache_addr_o !== 32'h8000_0004) begin n_fail++; $display("FAIL straddle.run_addr got %h want 80000004", icache_addr_o); end
        n_cmp++; if (instr_o !== 32'h0000_ABCD) begin n_fail++; $display("FAIL straddle.run_instr got %h want 0000abcd", instr_o); end
        n_cmp++; if (pc_aligned_o !== 32'h8000_0006) begin n_fail++; $display("FAIL straddle.run_pc got %h want 80000006", pc_aligned_o); end
        tick();
    endtask

    task automatic test_split_if_stall();
        enter_split();
        icache_valid_i = 1'b1;
        icache_rdata_i = 32'h5555_0050;
        if_stall_i     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL split_hold.instr[%0d] got %h want 00500093", i, instr_o); end
            n_cmp++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL split_hold.valid[%0d] got %b want 1", i, instr_valid_o); end
            n_cmp++; if (icache_addr_o !== 32'h8000_0004) begin n_fail++; $display("FAIL split_hold.addr[%0d] got %h want 80000004", i, icache_addr_o); end
            tick();
        end
        if_stall_i = 1'b0;
        #1;
        n_cmp++; if (instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL split_hold.release_instr got %h want 00500093", instr_o); end
        tick();
        pc_ff_i        = 32'h8000_0006;
        icache_valid_i = 1'b0;
        #1;
        n_cmp++; if (icache_addr_o !== 32'h8000_0004) begin n_fail++; $display("FAIL split_hold.run_addr got %h want 80000004", icache_addr_o); end
        n_cmp++; if (pc_aligned_o !== 32'h8000_0006) begin n_fail++; $display("FAIL split_hold.run_pc got %h want 80000006", pc_aligned_o); end
        tick();
    endtask

    task automatic test_flush_split();
        enter_split();
        icache_valid_i = 1'b1;
        icache_rdata_i = 32'hABCD_0050;
        flush_i        = 1'b1;
        #1;
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush.valid got %b want 0", instr_valid_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush.stall got %b want 0", stall_o); end
        tick();
        flush_i        = 1'b0;
        icache_valid_i = 1'b0;
        pc_ff_i        = 32'h8000_0010;
        #1;
        n_cmp++; if (icache_addr_o !== 32'h8000_0010) begin n_fail++; $display("FAIL flush.run_addr got %h want 80000010", icache_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush.run_valid got %b want 0", instr_valid_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush.run_stall got %b want 0", stall_o); end
        n_cmp++; if (pc_aligned_o !== 32'h8000_0010) begin n_fail++; $display("FAIL flush.run_pc got %h want 80000010", pc_aligned_o); end
        tick();
    endtask

    task automatic test_reset_mid_split();
        enter_split();
        icache_valid_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (icache_addr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_split.addr got %h want 80000000", icache_addr_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_split.stall got %b want 0", stall_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_split.valid got %b want 0", instr_valid_o); end
        pc_ff_i        = 32'h8000_0000;
        icache_valid_i = 1'b1;
        icache_rdata_i = 32'h0050_0093;
        #1;
        n_cmp++; if (instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL rst_split.run_instr got %h want 00500093", instr_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask
`else
    task automatic test_misalign();
        do_reset();
        pc_ff_i        = 32'h8000_0002;
        icache_valid_i = 1'b1;
        icache_rdata_i = 32'h0003_4085;
        #1;
        n_cmp++; if (misalign_exc_o !== 1'b1) begin n_fail++; $display("FAIL misalign.exc got %b want 1", misalign_exc_o); end
        n_cmp++; if (instr_o !== NOP_I) begin n_fail++; $display("FAIL misalign.instr got %h want %h", instr_o, NOP_I); end
        n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL misalign.stall got %b want 0", stall_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL misalign.valid got %b want 0", instr_valid_o); end
        tick();
        pc_ff_i        = 32'h8000_0004;
        icache_rdata_i = 32'h0050_0093;
        #1;
        n_cmp++; if (misalign_exc_o !== 1'b0) begin n_fail++; $display("FAIL misalign.next_exc got %b want 0", misalign_exc_o); end
        n_cmp++; if (instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL misalign.next_instr got %h want 00500093", instr_o); end
        tick();
    endtask
`endif

    // Randomized traffic against a model built from the realignment rules:
    // pick the addressed halfword, classify it by its low two bits, and when a
    // 32-bit instruction starts in the upper half remember that half until the
    // next word arrives.
    task automatic test_random();
        bit          pend;
        logic [15:0] p_half;
        logic [31:0] p_pc;
        logic [31:0] pc, rd, e_instr, e_addr, e_pcal;
        logic [15:0] hw;
        logic        vld, e_comp, e_iv, e_stall, e_exc;
        pend   = 1'b0;
        p_half = 16'h0;
        p_pc   = 32'h0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            pc = $urandom & 32'hFFFF_FFFE;
            rd = $urandom;
            if ($urandom_range(0, 1) == 1) rd = rd | 32'h0003_0000;
            if ($urandom_range(0, 2) == 0) rd = rd | 32'h0000_0003;
            vld            = ($urandom_range(0, 3) != 0);
            pc_ff_i        = pc;
            icache_rdata_i = rd;
            icache_valid_i = vld;
            if_stall_i     = ($urandom_range(0, 3) == 0);
            flush_i        = ($urandom_range(0, 11) == 0);

            hw      = 16'((rd >> (16 * (pc % 4 / 2))) & 32'hFFFF);
            e_instr = NOP_I;
            e_comp  = 1'b0;
            e_iv    = 1'b0;
            e_stall = 1'b0;
            e_exc   = 1'b0;
            if (pend) begin
                e_addr = (p_pc / 4) * 4 + 4;
                e_pcal = p_pc;
                if (vld) begin
                    e_instr = (rd % 65536) * 65536 + 32'(p_half);
                    e_iv    = 1'b1;
                end else begin
                    e_stall = 1'b1;
                end
            end else begin
                e_addr = (pc / 4) * 4;
                e_pcal = pc;
                if (vld) begin
                    if (hw % 4 != 3) begin
                        e_instr = 32'(hw);
                        e_comp  = 1'b1;
                        e_iv    = 1'b1;
                    end else if (pc % 4 < 2) begin
                        e_instr = rd;
                        e_iv    = 1'b1;
                    end else if (SPLIT_EN) begin
                        e_stall = 1'b1;
                    end else begin
                        e_exc = 1'b1;
                    end
                end
            end
            if (flush_i) begin
                e_iv    = 1'b0;
                e_stall = 1'b0;
            end

            #1;
            n_cmp++; if (icache_addr_o !== e_addr) begin n_fail++; $display("FAIL rand[%0d].addr got %h want %h", i, icache_addr_o, e_addr); end
            n_cmp++; if (pc_aligned_o !== e_pcal) begin n_fail++; $display("FAIL rand[%0d].pc got %h want %h", i, pc_aligned_o, e_pcal); end
            n_cmp++; if (instr_valid_o !== e_iv) begin n_fail++; $display("FAIL rand[%0d].valid got %b want %b", i, instr_valid_o, e_iv); end
            n_cmp++; if (stall_o !== e_stall) begin n_fail++; $display("FAIL rand[%0d].stall got %b want %b", i, stall_o, e_stall); end
            if (!flush_i) begin
                n_cmp++; if (instr_o !== e_instr) begin n_fail++; $display("FAIL rand[%0d].instr got %h want %h", i, instr_o, e_instr); end
                n_cmp++; if (is_comp_o !== e_comp) begin n_fail++; $display("FAIL rand[%0d].comp got %b want %b", i, is_comp_o, e_comp); end
                n_cmp++; if (misalign_exc_o !== e_exc) begin n_fail++; $display("FAIL rand[%0d].exc got %b want %b", i, misalign_exc_o, e_exc); end
            end

            if (flush_i) begin
                pend = 1'b0;
            end else if (pend) begin
                if (vld && !if_stall_i) pend = 1'b0;
            end else if (SPLIT_EN && vld && (pc % 4 >= 2) && (hw % 4 == 3) && !if_stall_i) begin
                pend   = 1'b1;
                p_half = hw;
                p_pc   = pc;
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_aligned32();
        test_comp_pair();
`ifdef CEXT_SPLIT_FETCH_EN
        test_straddle();
        test_split_if_stall();
        test_flush_split();
        test_reset_mid_split();
`else
        test_misalign();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cext_aligner.md
# cext_aligner

Instruction realigner for the compressed (C) extension, sitting between the instruction cache response and the fetch stage. It owns the fetch-side `if2cext`/`cext2if` contract:
- Consumes the raw 32-bit cache word and the fetch PC.
- Selects the 16- or 32-bit instruction at a halfword-aligned PC and reports its size so fetch can advance by 2 or 4.
- Stalls fetch while a 32-bit instruction straddling a word boundary is assembled from two cache words.

## Interface
Parameters:
- XLEN, 32, PC/address width.
- NOP, 32'h0000_0013, instruction emitted when no valid instruction is available.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_ff_i  in  XLEN  current fetch PC (halfword aligned, bit 0 ignored).
- icache_valid_i  in  1  cache ack; icache_rdata_i valid this cycle.
- icache_rdata_i  in  32  word at icache_addr_o.
- if_stall_i  in  1  fetch held by forward/stall unit.
- flush_i  in  1  redirect (csr/exe new-PC request or wfi).
- icache_addr_o  out  XLEN  word-aligned address fetch must present to the cache.
- instr_o  out  32  selected instruction; compressed ones zero-extended in [31:16].
- is_comp_o  out  1  instr_o is 16-bit.
- pc_aligned_o  out  XLEN  PC of instr_o; fetch computes next PC = pc_aligned_o + (is_comp_o ? 2 : 4).
- instr_valid_o  out  1  instr_o is a real instruction.
- stall_o  out  1  fetch must hold pc_ff.
- misalign_exc_o  out  1  unsupported straddling instruction (see Configuration).

## Operation
- States: RUN, SPLIT. Registers: state, hbuf[15:0] (lower half of the straddling instruction), spc[XLEN-1:0] (its PC).
- RUN:
  - icache_addr_o = {pc_ff_i[XLEN-1:2], 2'b00}.
  - With icache_valid_i=0: instr_o=NOP, instr_valid_o=0, is_comp_o=0, stall_o=0.
  - pc_ff_i[1]=0, h=rdata[15:0]: h[1:0]!=2'b11 gives instr_o={16'h0,h}, is_comp_o=1. Otherwise instr_o=rdata, is_comp_o=0.
  - pc_ff_i[1]=1, h=rdata[31:16]: h[1:0]!=2'b11 gives instr_o={16'h0,h}, is_comp_o=1.
  - pc_ff_i[1]=1 and h[1:0]=2'b11 is a straddle:
    - instr_valid_o=0, stall_o=1.
    - On the clock edge with ~if_stall_i & ~flush_i: hbuf<=h, spc<=pc_ff_i, state<=SPLIT.
  - pc_aligned_o=pc_ff_i.
- SPLIT:
  - icache_addr_o = {spc[XLEN-1:2], 2'b00} + 4.
  - pc_aligned_o=spc.
  - stall_o = ~icache_valid_i.
  - On icache_valid_i: instr_o={rdata[15:0], hbuf}, is_comp_o=0, instr_valid_o=1.
  - Transition to RUN on icache_valid_i & ~if_stall_i. While if_stall_i=1, remain in SPLIT and keep driving the assembled instruction.
- flush_i has priority over every transition:
  - Next state RUN, hbuf<=0.
  - Outputs that cycle: instr_valid_o=0, stall_o=0.
- After SPLIT completes, fetch advances to spc+4 (pc[1]=1). The second word is re-fetched. No reuse buffer is implemented.
- Reset values: state=RUN, hbuf=0, spc=0. Outputs follow RUN decode with icache_valid_i=0: instr_o=NOP, instr_valid_o=0, is_comp_o=0, stall_o=0, misalign_exc_o=0, icache_addr_o=word(pc_ff_i), pc_aligned_o=pc_ff_i.

## Timing
- RUN decode is combinational from icache_valid_i/icache_rdata_i to instr_o/is_comp_o/stall_o. Zero added latency.
- A straddle costs exactly one extra cache access: minimum 2 cycles for the instruction, with stall_o high in the first cycle.
- State updates on posedge clk only. rst_n clears all registers immediately, including mid-SPLIT.
- flush_i in the same cycle as SPLIT completion: flush wins and the assembled instruction is discarded.
- stall_o never depends on if_stall_i. No combinational loop through the fetch stall.

## Configuration
- Macro: CEXT_SPLIT_FETCH_EN.
- Defined: full SPLIT behaviour as above; misalign_exc_o tied 0.
- Undefined:
  - No SPLIT state, hbuf or spc.
  - A straddle in RUN gives instr_o=NOP, instr_valid_o=0, stall_o=0, misalign_exc_o=1 (combinational, same cycle).
  - Fetch/ID raises the instruction-misaligned exception from this signal.

## Test plan
- Aligned 32-bit: pc=0x8000_0000, rdata=0x0050_0093 -> instr_o=0x0050_0093, is_comp_o=0, instr_valid_o=1, stall_o=0.
- Compressed pair in one word: pc=0x8000_0000 then 0x8000_0002, rdata=0x4501_4085 -> cycle 1 instr_o=0x0000_4085, is_comp_o=1. Cycle 2 instr_o=0x0000_4501, pc_aligned_o=0x8000_0002.
- Straddle (macro on): pc=0x8000_0002, word0=0x0093_xxxx, word1=0xxxxx_0050 -> cycle 1 stall_o=1, icache_addr_o=0x8000_0004. Next ack: instr_o=0x0050_0093, pc_aligned_o=0x8000_0002, stall_o=0, then state RUN.
- Straddle with if_stall_i held 3 cycles on completion -> stays SPLIT, instr_o stable at 0x0050_0093; RUN on the first cycle with if_stall_i=0.
- flush_i in SPLIT, and separately rst_n low mid-SPLIT -> next cycle state RUN, hbuf=0, instr_valid_o=0, icache_addr_o=word(pc_ff_i).
- Macro off, pc=0x8000_0002, rdata[17:16]=2'b11 -> misalign_exc_o=1, instr_o=0x0000_0013, stall_o=0.
